// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encoding and default sizing of the watchdog and event counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } pipeState_t;

  localparam int DEF_CNT_W     = 32;
  localparam int DEF_MAX_STALL = 15;
  localparam int DEF_STALL_W   = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. A synchronous
// clear has priority over the enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Clear, else count up until all-ones is reached.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage datapath. Turns the hazard unit's
// stall request and decode-stage redirects into PC / IF/ID / ID/EX controls
// in the same cycle, and keeps a consecutive-stall watchdog plus saturating
// stall and flush event counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STALL = DEF_MAX_STALL,
  parameter int STALL_W   = DEF_STALL_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             StallReq,
  input  logic             BranchTaken,
  input  logic             JumpTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             StallTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       DbgState
);

  // The watchdog trips on the edge that completes the MAX_STALL-th
  // consecutive stalled cycle, i.e. when the run count is MAX_STALL-1 going in.
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL - 1);

  pipeState_t         state;
  logic               stallCycle;
  logic               redirect;
  logic [STALL_W-1:0] stallRun;

  // HOLD ignores every input, so nothing is counted while in it. A stall
  // always wins over a redirect: the branch operands are not valid yet.
  assign stallCycle = (state != HOLD) && StallReq;
  assign redirect   = (state != HOLD) && !StallReq && (BranchTaken || JumpTaken);
  assign DbgState   = state;

  // State register: one HOLD cycle out of reset, then track the stall request.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= HOLD;
    end else begin
      case (state)
        HOLD:    state <= RUN;
        RUN:     state <= StallReq ? STALL : RUN;
        STALL:   state <= StallReq ? STALL : RUN;
        default: state <= HOLD;
      endcase
    end
  end

  // Same-cycle stage controls from current state and hazard inputs.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (state == HOLD) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (StallReq) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (redirect) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  // Sticky watchdog flag; diagnostic only, controls are unaffected.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallTimeout <= 1'b0;
    end else if (stallCycle && (stallRun >= STALL_LIMIT)) begin
      StallTimeout <= 1'b1;
    end
  end

  sat_counter #(.W(STALL_W)) uStallRun (
    .clk   (Clk),
    .rstN  (Rst_n),
    .en    (stallCycle),
    .clr   (!stallCycle),
    .count (stallRun)
  );

  sat_counter #(.W(CNT_W)) uStallCount (
    .clk   (Clk),
    .rstN  (Rst_n),
    .en    (stallCycle),
    .clr   (1'b0),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) uFlushCount (
    .clk   (Clk),
    .rstN  (Rst_n),
    .en    (redirect),
    .clr   (1'b0),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Two instances share all inputs:
// one with default sizing, one with 4-bit event counters for saturation.
module tb_pipeline_stall_ctrl;

  // Control nibble order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  localparam logic [3:0] C_HOLD  = 4'b0011;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1110;
  localparam logic [3:0] C_RUN   = 4'b1100;

  logic        Clk;
  logic        Rst_n;
  logic        StallReq;
  logic        BranchTaken;
  logic        JumpTaken;

  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, StallTimeout;
  logic [31:0] StallCount, FlushCount;
  logic [1:0]  DbgState;

  logic        PCWrite4, IF_ID_Write4, IF_ID_Flush4, ID_EX_Bubble4, StallTimeout4;
  logic [3:0]  StallCount4, FlushCount4;
  logic [1:0]  DbgState4;

  int checkCount = 0;
  int failCount  = 0;

  wire [3:0] ctrl  = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble};
  wire [3:0] ctrl4 = {PCWrite4, IF_ID_Write4, IF_ID_Flush4, ID_EX_Bubble4};

  pipeline_stall_ctrl dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .StallReq     (StallReq),
    .BranchTaken  (BranchTaken),
    .JumpTaken    (JumpTaken),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Bubble (ID_EX_Bubble),
    .StallTimeout (StallTimeout),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount),
    .DbgState     (DbgState)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .StallReq     (StallReq),
    .BranchTaken  (BranchTaken),
    .JumpTaken    (JumpTaken),
    .PCWrite      (PCWrite4),
    .IF_ID_Write  (IF_ID_Write4),
    .IF_ID_Flush  (IF_ID_Flush4),
    .ID_EX_Bubble (ID_EX_Bubble4),
    .StallTimeout (StallTimeout4),
    .StallCount   (StallCount4),
    .FlushCount   (FlushCount4),
    .DbgState     (DbgState4)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Full reset: one cycle low, release, then step through the HOLD cycle.
  task automatic resetDut;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
  endtask

  initial begin
    Rst_n = 1'b0; StallReq = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0;

    // Reset held for 3 cycles: HOLD controls, cleared counters.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkEq("rst_ctrl", 32'(ctrl), 32'(C_HOLD));
      checkEq("rst_state", 32'(DbgState), 32'd0);
    end
    checkEq("rst_stallcnt", StallCount, 32'd0);
    checkEq("rst_flushcnt", FlushCount, 32'd0);
    checkEq("rst_timeout", 32'(StallTimeout), 32'd0);

    // Release; HOLD lasts one cycle and a branch during it is ignored.
    tick();
    Rst_n = 1'b1;
    BranchTaken = 1'b1;
    #1;
    checkEq("hold_ctrl", 32'(ctrl), 32'(C_HOLD));
    tick();
    BranchTaken = 1'b0;
    #1;
    checkEq("run_ctrl", 32'(ctrl), 32'(C_RUN));
    checkEq("run_state", 32'(DbgState), 32'd1);
    checkEq("hold_flushcnt", FlushCount, 32'd0);

    // Single-cycle load-use stall.
    StallReq = 1'b1;
    #1;
    checkEq("lu_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    StallReq = 1'b0;
    #1;
    checkEq("lu_stallcnt", StallCount, 32'd1);
    checkEq("lu_state", 32'(DbgState), 32'd2);
    checkEq("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    checkEq("lu_back_state", 32'(DbgState), 32'd1);

    // Branch then jump redirect.
    BranchTaken = 1'b1;
    #1;
    checkEq("br_ctrl", 32'(ctrl), 32'(C_FLUSH));
    tick();
    BranchTaken = 1'b0;
    #1;
    checkEq("br_flushcnt", FlushCount, 32'd1);
    JumpTaken = 1'b1;
    #1;
    checkEq("jmp_ctrl", 32'(ctrl), 32'(C_FLUSH));
    tick();
    JumpTaken = 1'b0;
    #1;
    checkEq("jmp_flushcnt", FlushCount, 32'd2);

    // Simultaneous stall and branch: stall wins, branch honoured next cycle.
    resetDut();
    StallReq = 1'b1; BranchTaken = 1'b1;
    #1;
    checkEq("sim_stall_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    StallReq = 1'b0;
    #1;
    checkEq("sim_flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
    checkEq("sim_flushcnt0", FlushCount, 32'd0);
    tick();
    BranchTaken = 1'b0;
    #1;
    checkEq("sim_stallcnt", StallCount, 32'd1);
    checkEq("sim_flushcnt", FlushCount, 32'd1);

    // Watchdog: 16 consecutive stalls, trips after the 15th edge.
    resetDut();
    StallReq = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkEq($sformatf("wd_timeout_%0d", i), 32'(StallTimeout), (i >= 15) ? 32'd1 : 32'd0);
    end
    checkEq("wd_ctrl", 32'(ctrl), 32'(C_STALL));
    StallReq = 1'b0;
    tick();
    checkEq("wd_sticky", 32'(StallTimeout), 32'd1);
    checkEq("wd_stallcnt", StallCount, 32'd16);
    checkEq("wd_stallcnt4", 32'(StallCount4), 32'd15);
    Rst_n = 1'b0;
    #1;
    checkEq("wd_rst_timeout", 32'(StallTimeout), 32'd0);
    tick();
    Rst_n = 1'b1;
    tick();

    // Saturation on the 4-bit instance, then asynchronous reset mid-stall.
    StallReq = 1'b1;
    repeat (20) tick();
    checkEq("sat_stallcnt4", 32'(StallCount4), 32'd15);
    checkEq("sat_stallcnt", StallCount, 32'd20);
    #2;
    Rst_n = 1'b0;
    #1;
    checkEq("mid_ctrl", 32'(ctrl), 32'(C_HOLD));
    checkEq("mid_ctrl4", 32'(ctrl4), 32'(C_HOLD));
    checkEq("mid_stallcnt", StallCount, 32'd0);
    checkEq("mid_stallcnt4", 32'(StallCount4), 32'd0);
    checkEq("mid_timeout", 32'(StallTimeout), 32'd0);
    checkEq("mid_state", 32'(DbgState), 32'd0);
    StallReq = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline stall and flush controller for the 5-stage MIPS datapath. It consumes the hazard unit's stall request and the decode-stage branch/jump resolution. It produces the per-stage write-enable and bubble/flush controls for PC, IF/ID and ID/EX. It also keeps a stall watchdog and saturating stall/flush event counters, readable by the testbench and the display logic.

## Interface
- `CNT_W`, default 32: width of the event counters.
- `MAX_STALL`, default 15: consecutive-stall limit before the watchdog trips (1..2^STALL_W−1).
- `STALL_W`, default 4: width of the consecutive-stall counter.
- `Clk` input 1: system clock, rising edge.
- `Rst_n` input 1: asynchronous, active-low reset. One clock domain; reset polarity and asynchronous assertion are fixed.
- `StallReq` input 1: hazard unit request, 1 = hold IF/ID and insert a bubble.
- `BranchTaken` input 1: branch resolved taken in decode this cycle.
- `JumpTaken` input 1: j/jal/jr in decode this cycle.
- `PCWrite` output 1: PC register enable.
- `IF_ID_Write` output 1: IF/ID register enable.
- `IF_ID_Flush` output 1: zero IF/ID on the next edge.
- `ID_EX_Bubble` output 1: select nop control signals into ID/EX.
- `StallTimeout` output 1: sticky watchdog flag.
- `StallCount` output CNT_W: cycles spent stalled, saturating.
- `FlushCount` output CNT_W: redirects taken, saturating.

## Operation
- FSM states:
  - HOLD: entered on reset; lasts exactly 1 cycle after `Rst_n` rises.
  - RUN.
  - STALL.
- Transitions:
  - HOLD → RUN unconditionally.
  - RUN → STALL when `StallReq`=1.
  - STALL → RUN when `StallReq`=0.
  - STALL → STALL while `StallReq`=1.
- Control outputs are combinational from state and inputs. This is required because decode-stage hazards must act in the same cycle.
- HOLD:
  - `PCWrite`=0, `IF_ID_Write`=0, `IF_ID_Flush`=1, `ID_EX_Bubble`=1.
- RUN or STALL with `StallReq`=1:
  - `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Bubble`=1, `IF_ID_Flush`=0.
  - `BranchTaken` and `JumpTaken` are ignored, because the decoded branch operands are not yet valid.
- `StallReq`=0 with (`BranchTaken` or `JumpTaken`)=1:
  - `PCWrite`=1, `IF_ID_Write`=1, `IF_ID_Flush`=1, `ID_EX_Bubble`=0.
- Otherwise: `PCWrite`=1, `IF_ID_Write`=1, `IF_ID_Flush`=0, `ID_EX_Bubble`=0.
- Consecutive-stall counter (STALL_W bits):
  - Increments each cycle with `StallReq`=1, saturating at all-ones.
  - Clears on any cycle with `StallReq`=0.
  - When it reaches MAX_STALL with `StallReq` still 1, `StallTimeout` sets on that edge.
  - `StallTimeout` is cleared only by reset.
  - Stall control outputs are still honoured after a timeout; the flag is diagnostic only.
- `StallCount` increments on every edge where a stall cycle occurred (`StallReq`=1 and state ≠ HOLD).
- `FlushCount` increments on every edge where a redirect was honoured.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset values: state HOLD, all counters 0, `StallTimeout`=0. While `Rst_n`=0, control outputs hold the HOLD values: `PCWrite`=0, `IF_ID_Write`=0, `IF_ID_Flush`=1, `ID_EX_Bubble`=1.
- Control outputs have zero latency from inputs. Counters and the flag update one edge after the qualifying cycle.
- A simultaneous stall and branch produce one stall cycle with no flush. The branch is re-evaluated in the following un-stalled cycle.
- Reset asserted mid-stall returns to HOLD immediately and asynchronously. Counters clear with no partial increment.
- Inputs during HOLD are ignored and counted nowhere.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - State encoding: HOLD=2'b00, RUN=2'b01, STALL=2'b10.
  - Default CNT_W, MAX_STALL, STALL_W constants.
- One sub-module, `sat_counter` (parameterised width, enable, synchronous clear, asynchronous active-low reset). It is instantiated three times: stall run, StallCount, FlushCount.

## Test plan
- Reset release:
  - Hold `Rst_n`=0 for 3 cycles, then release with `StallReq`=0.
  - Expect HOLD outputs for those 3 cycles plus the first cycle after release (`PCWrite`=0, `IF_ID_Flush`=1).
  - Expect RUN outputs (`PCWrite`=1, `IF_ID_Write`=1, flush/bubble 0) from the second cycle after release.
- Load-use stall:
  - Pulse `StallReq` for 1 cycle in RUN.
  - Expect `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Bubble`=1 for that cycle only; `StallCount`=1 after the edge.
- Branch redirect:
  - Drive `BranchTaken`=1 for 1 cycle.
  - Expect `IF_ID_Flush`=1, `PCWrite`=1, `ID_EX_Bubble`=0; `FlushCount`=1.
  - Repeat with `JumpTaken` and expect `FlushCount`=2.
- Simultaneous stall and branch:
  - Drive `StallReq`=1 and `BranchTaken`=1 for 1 cycle, then `BranchTaken` alone.
  - First cycle: `IF_ID_Flush`=0 and stall outputs.
  - Second cycle: flush; `StallCount`=1, `FlushCount`=1.
- Watchdog:
  - Hold `StallReq`=1 for 16 cycles with MAX_STALL=15.
  - `StallTimeout` rises after the 15th stalled edge and stays 1 after `StallReq` drops; `StallCount`=16.
  - Assert reset and expect it to clear.
- Saturation and mid-stall reset:
  - With CNT_W=4, stall 20 cycles: `StallCount`=15.
  - Assert `Rst_n`=0 mid-stall: outputs take HOLD values asynchronously and the counters read 0.
